// File: rtl/sram_arbiter_wb8.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter_wb8
// Brief    : Slot arbiter between a VGA raw read port (absolute priority) and
//            a Wishbone B4 classic 8-bit CPU port onto an async 8-bit SRAM.
//            Optional macro SRAM_ARB_WR_SETUP_EN adds a write setup slot.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter_wb8 #(
    parameter int ADR_WIDTH = 19
) (
    input  logic                 I_clk,
    input  logic                 I_reset,
    input  logic [ADR_WIDTH-1:0] I_wb_adr,
    input  logic [7:0]           I_wb_dat,
    input  logic                 I_wb_stb,
    input  logic                 I_wb_we,
    output logic                 O_wb_ack,
    output logic [7:0]           O_wb_dat,
    input  logic                 I_vga_req,
    input  logic [ADR_WIDTH-1:0] I_vga_adr,
    output logic [7:0]           O_vga_dat,
    output logic [ADR_WIDTH-1:0] O_sram_adr,
    output logic [7:0]           O_sram_dat,
    output logic                 O_sram_dat_oe,
    input  logic [7:0]           I_sram_dat,
    output logic                 O_sram_oe_n,
    output logic                 O_sram_we_n
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU    = 2'd1,
        ACK    = 2'd2,
        WSETUP = 2'd3
    } state_t;

    state_t r_state;
    logic   r_cpu_we;

    // The VGA controller samples the pins directly one slot after its request.
    assign O_vga_dat = I_sram_dat;

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            r_state       <= IDLE;
            r_cpu_we      <= 1'b0;
            O_sram_adr    <= '0;
            O_sram_dat    <= 8'h00;
            O_sram_dat_oe <= 1'b0;
            O_sram_oe_n   <= 1'b1;
            O_sram_we_n   <= 1'b1;
            O_wb_ack      <= 1'b0;
            O_wb_dat      <= 8'h00;
        end else begin
            // Every edge closes the previous slot; a VGA request may open the next.
            O_sram_we_n   <= 1'b1;
            O_sram_oe_n   <= 1'b1;
            O_sram_dat_oe <= 1'b0;
            if (I_vga_req) begin
                O_sram_adr  <= I_vga_adr;
                O_sram_oe_n <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (!I_vga_req && I_wb_stb) begin
                        O_sram_adr <= I_wb_adr;
                        r_cpu_we   <= I_wb_we;
                        if (I_wb_we) begin
                            O_sram_dat    <= I_wb_dat;
                            O_sram_dat_oe <= 1'b1;
`ifdef SRAM_ARB_WR_SETUP_EN
                            r_state       <= WSETUP;
`else
                            O_sram_we_n   <= 1'b0;
                            r_state       <= CPU;
`endif
                        end else begin
                            O_sram_oe_n <= 1'b0;
                            r_state     <= CPU;
                        end
                    end
                end
`ifdef SRAM_ARB_WR_SETUP_EN
                WSETUP: begin
                    // A VGA request here costs the setup slot; IDLE reopens it.
                    if (I_vga_req) begin
                        r_state <= IDLE;
                    end else begin
                        O_sram_dat_oe <= 1'b1;
                        O_sram_we_n   <= 1'b0;
                        r_state       <= CPU;
                    end
                end
`endif
                CPU: begin
                    if (!r_cpu_we) begin
                        O_wb_dat <= I_sram_dat;
                    end
                    O_wb_ack <= 1'b1;
                    r_state  <= ACK;
                end
                ACK: begin
                    // stb is still high here; ignoring it prevents a double issue.
                    O_wb_ack <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter_wb8.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_arbiter_wb8
// Brief    : Self-checking bench for sram_arbiter_wb8 with an async SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter_wb8;

    localparam int ADR_WIDTH = 19;
`ifdef SRAM_ARB_WR_SETUP_EN
    localparam int WR_LAT = 3;
`else
    localparam int WR_LAT = 2;
`endif

    logic                 I_clk = 1'b0;
    logic                 I_reset = 1'b1;
    logic [ADR_WIDTH-1:0] I_wb_adr = '0;
    logic [7:0]           I_wb_dat = 8'h00;
    logic                 I_wb_stb = 1'b0;
    logic                 I_wb_we = 1'b0;
    logic                 O_wb_ack;
    logic [7:0]           O_wb_dat;
    logic                 I_vga_req = 1'b0;
    logic [ADR_WIDTH-1:0] I_vga_adr = '0;
    logic [7:0]           O_vga_dat;
    logic [ADR_WIDTH-1:0] O_sram_adr;
    logic [7:0]           O_sram_dat;
    logic                 O_sram_dat_oe;
    logic [7:0]           I_sram_dat;
    logic                 O_sram_oe_n;
    logic                 O_sram_we_n;

    sram_arbiter_wb8 #(.ADR_WIDTH(ADR_WIDTH)) dut (
        .I_clk        (I_clk),
        .I_reset      (I_reset),
        .I_wb_adr     (I_wb_adr),
        .I_wb_dat     (I_wb_dat),
        .I_wb_stb     (I_wb_stb),
        .I_wb_we      (I_wb_we),
        .O_wb_ack     (O_wb_ack),
        .O_wb_dat     (O_wb_dat),
        .I_vga_req    (I_vga_req),
        .I_vga_adr    (I_vga_adr),
        .O_vga_dat    (O_vga_dat),
        .O_sram_adr   (O_sram_adr),
        .O_sram_dat   (O_sram_dat),
        .O_sram_dat_oe(O_sram_dat_oe),
        .I_sram_dat   (I_sram_dat),
        .O_sram_oe_n  (O_sram_oe_n),
        .O_sram_we_n  (O_sram_we_n)
    );

    always #5 I_clk = ~I_clk;

    // Async SRAM model: reads drive the bus only while oe_n is low.
    logic [7:0] mem [0:(1<<ADR_WIDTH)-1];
    assign I_sram_dat = (!O_sram_oe_n) ? mem[O_sram_adr] : 8'hEE;

    int total = 0;
    int bad = 0;
    int we_cnt = 0;
    int ack_cnt = 0;
    logic [ADR_WIDTH-1:0] last_we_adr;
    logic [7:0]           last_we_dat;
    logic                 last_we_oe;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endfunction

    always @(negedge I_clk) begin
        if (!I_reset) begin
            chk("oe_we_exclusive", {31'd0, !O_sram_oe_n && !O_sram_we_n}, 32'd0);
        end
        if (!O_sram_we_n) begin
            we_cnt++;
            last_we_adr = O_sram_adr;
            last_we_dat = O_sram_dat;
            last_we_oe  = O_sram_dat_oe;
            mem[O_sram_adr] = O_sram_dat;
        end
        if (O_wb_ack) ack_cnt++;
    end

    // One Wishbone cycle; called #1 after an active edge.
    task automatic wb_cycle(input logic we, input logic [ADR_WIDTH-1:0] adr,
                            input logic [7:0] dat, output int lat, output logic [7:0] rd);
        I_wb_stb = 1'b1;
        I_wb_we  = we;
        I_wb_adr = adr;
        I_wb_dat = dat;
        lat = 0;
        do begin
            @(posedge I_clk);
            #1;
            lat++;
        end while (!O_wb_ack && lat < 20);
        if (!O_wb_ack) chk("wb_ack_timeout", 32'd0, 32'd1);
        rd = O_wb_dat;
        I_wb_stb = 1'b0;
        I_wb_we  = 1'b0;
    endtask

    typedef struct {
        logic                 we;
        logic [ADR_WIDTH-1:0] adr;
        logic [7:0]           dat;   // write data, or expected read data
    } vec_t;

    vec_t       vecs [10];
    logic [7:0] sb_q [$];

    initial begin
        int lat;
        int a0, w0;
        logic [7:0] rd;

        vecs[0] = '{1'b1, 19'h20000, 8'hA5};
        vecs[1] = '{1'b0, 19'h20000, 8'hA5};
        vecs[2] = '{1'b1, 19'h00000, 8'h00};
        vecs[3] = '{1'b1, 19'h7FFFF, 8'hFF};
        vecs[4] = '{1'b1, 19'h00001, 8'h5A};
        vecs[5] = '{1'b0, 19'h7FFFF, 8'hFF};
        vecs[6] = '{1'b0, 19'h00000, 8'h00};
        vecs[7] = '{1'b0, 19'h00001, 8'h5A};
        vecs[8] = '{1'b1, 19'h20000, 8'h3C};
        vecs[9] = '{1'b0, 19'h20000, 8'h3C};

        mem[19'h12345] = 8'h00;
        mem[19'h40041] = 8'h3C;
        mem[19'h00300] = 8'h11;
        for (int k = 0; k < 6; k++) mem[19'h00100 + k] = 8'h10 + 8'(k);

        // Reset with a write request already pending
        I_wb_stb = 1'b1; I_wb_we = 1'b1; I_wb_adr = 19'h12345; I_wb_dat = 8'h77;
        repeat (3) @(posedge I_clk);
        #1;
        chk("rst_we_n", {31'd0, O_sram_we_n}, 32'd1);
        chk("rst_oe_n", {31'd0, O_sram_oe_n}, 32'd1);
        chk("rst_dat_oe", {31'd0, O_sram_dat_oe}, 32'd0);
        chk("rst_ack", {31'd0, O_wb_ack}, 32'd0);
        chk("rst_sram_adr", {13'd0, O_sram_adr}, 32'd0);
        chk("rst_sram_dat", {24'd0, O_sram_dat}, 32'd0);
        chk("rst_wb_dat", {24'd0, O_wb_dat}, 32'd0);
        a0 = ack_cnt; w0 = we_cnt;
        I_reset = 1'b0;
        wb_cycle(1'b1, 19'h12345, 8'h77, lat, rd);
        repeat (3) @(posedge I_clk);
        #1;
        chk("rst_rel_ack_count", ack_cnt - a0, 1);
        chk("rst_rel_we_count", we_cnt - w0, 1);
        chk("rst_rel_mem", {24'd0, mem[19'h12345]}, 32'h77);

        // Table-driven CPU transfers with a read-data scoreboard
        for (int i = 0; i < 10; i++) begin
            w0 = we_cnt; a0 = ack_cnt;
            if (!vecs[i].we) sb_q.push_back(vecs[i].dat);
            wb_cycle(vecs[i].we, vecs[i].adr, vecs[i].dat, lat, rd);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].we ? WR_LAT : 2);
            @(posedge I_clk);
            #1;
            chk($sformatf("v%0d_ack_pulse", i), ack_cnt - a0, 1);
            if (vecs[i].we) begin
                chk($sformatf("v%0d_we_count", i), we_cnt - w0, 1);
                chk($sformatf("v%0d_we_adr", i), {13'd0, last_we_adr}, {13'd0, vecs[i].adr});
                chk($sformatf("v%0d_we_dat", i), {24'd0, last_we_dat}, {24'd0, vecs[i].dat});
                chk($sformatf("v%0d_we_dat_oe", i), {31'd0, last_we_oe}, 32'd1);
            end else begin
                chk($sformatf("v%0d_no_write", i), we_cnt - w0, 0);
                if (sb_q.size() > 0) chk($sformatf("v%0d_rdata", i), {24'd0, rd}, {24'd0, sb_q.pop_front()});
                else chk("scoreboard_empty", 32'd0, 32'd1);
            end
        end

        // Single VGA read
        w0 = we_cnt;
        I_vga_req = 1'b1; I_vga_adr = 19'h40041;
        @(posedge I_clk);
        #1;
        I_vga_req = 1'b0;
        chk("vga_oe_n", {31'd0, O_sram_oe_n}, 32'd0);
        chk("vga_adr", {13'd0, O_sram_adr}, 32'h40041);
        @(negedge I_clk);
        chk("vga_dat", {24'd0, O_vga_dat}, 32'h3C);
        @(posedge I_clk);
        #1;
        chk("vga_no_write", we_cnt - w0, 0);

        // VGA request every second cycle with a concurrent CPU read
        mem[19'h00200] = 8'h99;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    I_vga_req = 1'b1; I_vga_adr = 19'h00100 + 19'(k);
                    @(posedge I_clk);
                    #1;
                    I_vga_req = 1'b0;
                    @(negedge I_clk);
                    chk($sformatf("vga_stream%0d", k), {24'd0, O_vga_dat}, {24'd0, 8'h10 + 8'(k)});
                    @(posedge I_clk);
                    #1;
                end
            end
            begin
                int clat;
                logic [7:0] crd;
                @(posedge I_clk);
                #1;
                sb_q.push_back(8'h99);
                wb_cycle(1'b0, 19'h00200, 8'h00, clat, crd);
                chk("cpu_lat_under_vga", {31'd0, clat <= 3}, 32'd1);
                chk("cpu_rdata_under_vga", {24'd0, crd}, {24'd0, sb_q.pop_front()});
            end
        join
        @(posedge I_clk);
        #1;

        // Simultaneous strobe and VGA request: VGA slot first
        a0 = ack_cnt;
        I_vga_req = 1'b1; I_vga_adr = 19'h40041;
        I_wb_stb = 1'b1; I_wb_we = 1'b0; I_wb_adr = 19'h20000;
        @(posedge I_clk);
        #1;
        I_vga_req = 1'b0;
        chk("sim_vga_first_adr", {13'd0, O_sram_adr}, 32'h40041);
        chk("sim_vga_first_oe_n", {31'd0, O_sram_oe_n}, 32'd0);
        @(posedge I_clk);
        #1;
        chk("sim_cpu_slot_adr", {13'd0, O_sram_adr}, 32'h20000);
        chk("sim_cpu_no_ack_yet", {31'd0, O_wb_ack}, 32'd0);
        @(posedge I_clk);
        #1;
        chk("sim_cpu_ack", {31'd0, O_wb_ack}, 32'd1);
        chk("sim_cpu_rdata", {24'd0, O_wb_dat}, 32'h3C);
        I_wb_stb = 1'b0;
        repeat (3) @(posedge I_clk);
        #1;
        chk("sim_single_ack", ack_cnt - a0, 1);

`ifdef SRAM_ARB_WR_SETUP_EN
        // Write whose setup slot is interrupted by VGA
        a0 = ack_cnt; w0 = we_cnt;
        I_wb_stb = 1'b1; I_wb_we = 1'b1; I_wb_adr = 19'h00400; I_wb_dat = 8'hC3;
        @(posedge I_clk);
        #1;
        chk("ws_setup_we_n", {31'd0, O_sram_we_n}, 32'd1);
        chk("ws_setup_dat_oe", {31'd0, O_sram_dat_oe}, 32'd1);
        I_vga_req = 1'b1; I_vga_adr = 19'h40041;
        @(posedge I_clk);
        #1;
        I_vga_req = 1'b0;
        chk("ws_vga_adr", {13'd0, O_sram_adr}, 32'h40041);
        chk("ws_vga_dat_oe", {31'd0, O_sram_dat_oe}, 32'd0);
        wb_cycle(1'b1, 19'h00400, 8'hC3, lat, rd);
        repeat (2) @(posedge I_clk);
        #1;
        chk("ws_we_count", we_cnt - w0, 1);
        chk("ws_mem", {24'd0, mem[19'h00400]}, 32'hC3);
        chk("ws_ack_count", ack_cnt - a0, 1);
`endif

        // Reset one cycle into a write: no ack, write enable released
        a0 = ack_cnt;
        I_wb_stb = 1'b1; I_wb_we = 1'b1; I_wb_adr = 19'h00300; I_wb_dat = 8'h66;
        @(posedge I_clk);
        #1;
        I_reset = 1'b1; I_wb_stb = 1'b0; I_wb_we = 1'b0;
        @(posedge I_clk);
        #1;
        chk("midrst_we_n", {31'd0, O_sram_we_n}, 32'd1);
        chk("midrst_dat_oe", {31'd0, O_sram_dat_oe}, 32'd0);
        I_reset = 1'b0;
        repeat (4) @(posedge I_clk);
        #1;
        chk("midrst_no_ack", ack_cnt - a0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_arbiter_wb8.md
Name: sram_arbiter_wb8

Overview:
- Single-clock arbiter between two masters and the board's external async 8-bit SRAM: the CPU, over a Wishbone B4 classic 8-bit slave port, and the VGA controller, over its read-only raw request port (req/adr in, dat out).
- VGA reads have absolute priority and a fixed read latency. CPU reads and writes are fitted into free SRAM slots.
- Sits between the VGA controller's external-RAM port and the SRAM pins; also the CPU's path to framebuffer and font memory.

Parameters:
ADR_WIDTH, 19, SRAM/Wishbone/VGA address width in bits (data width fixed at 8).

Ports:
I_clk  in  1  system clock; all logic on rising edge; VGA controller runs on this same clock
I_reset  in  1  synchronous, active-high reset
I_wb_adr  in  ADR_WIDTH  CPU byte address
I_wb_dat  in  8  CPU write data
I_wb_stb  in  1  CPU strobe; held by master until ack
I_wb_we  in  1  CPU write enable
O_wb_ack  out  1  one-cycle acknowledge
O_wb_dat  out  8  CPU read data, registered
I_vga_req  in  1  VGA read request, single-cycle pulse
I_vga_adr  in  ADR_WIDTH  VGA read address, valid with I_vga_req
O_vga_dat  out  8  VGA read data
O_sram_adr  out  ADR_WIDTH  SRAM address, registered
O_sram_dat  out  8  SRAM write data, registered
O_sram_dat_oe  out  1  drive enable for SRAM data pins (top level builds the tristate)
I_sram_dat  in  8  SRAM data pins, input side
O_sram_oe_n  out  1  SRAM output enable, active low, registered
O_sram_we_n  out  1  SRAM write enable, active low, registered

Behaviour:
- Reset (sync, high): O_sram_we_n=1, O_sram_oe_n=1, O_sram_dat_oe=0, O_sram_adr=0, O_sram_dat=0, O_wb_ack=0, O_wb_dat=0, FSM=IDLE. Reset mid-write: we_n high at the next edge; the transaction is dropped with no ack.
- Slot = one clock period between two edges. Slot owner and SRAM controls are registered at the slot's opening edge.
- VGA slot:
  - I_vga_req=1 at edge N: O_sram_adr<=I_vga_adr, oe_n<=0, we_n<=1, dat_oe<=0.
  - O_vga_dat is wired to I_sram_dat (not registered). The VGA controller samples it at edge N+1, i.e. two edges after it raised req.
  - VGA issues at most one req per 2 cycles; back-to-back reqs are still all served (the CPU simply stalls).
- FSM states IDLE, CPU, ACK:
  - IDLE, edge with !I_vga_req && I_wb_stb: open CPU slot, go to CPU.
    - Read: adr<=I_wb_adr, oe_n<=0, we_n<=1, dat_oe<=0.
    - Write: adr<=I_wb_adr, O_sram_dat<=I_wb_dat, dat_oe<=1, oe_n<=1, we_n<=0.
  - IDLE, edge with I_vga_req: VGA slot opens; a pending stb stays pending.
  - CPU, next edge:
    - Read: O_wb_dat<=I_sram_dat.
    - O_wb_ack<=1; go to ACK.
    - Same edge: we_n<=1, dat_oe<=0. A VGA slot may open at this edge; otherwise oe_n<=1.
  - ACK, next edge: O_wb_ack<=0; go to IDLE. No new stb is accepted in ACK (prevents double issue).
- CPU latency: stb seen at edge N with no VGA req gives ack visible after edge N+1. Each VGA req at an IDLE edge adds 1 cycle.
- Simultaneous I_vga_req and I_wb_stb: VGA wins.
- A CPU slot, once opened, is never preempted.
- Address/width: no arithmetic; addresses pass through unchanged at ADR_WIDTH bits.

Optional Feature:
SRAM_ARB_WR_SETUP_EN
- Defined: CPU writes take two consecutive CPU-owned slots, adding state WSETUP.
  - WSETUP slot: adr/data driven, dat_oe=1, we_n=1.
  - Following slot: we_n=0, then ack as above.
  - If I_vga_req occurs at the edge ending WSETUP: the VGA slot is served and the setup slot is repeated.
  - Write ack earliest after 3 edges.
- Undefined: single-slot writes as above; reads unaffected in both cases.

Test Plan:
- Reset with stb=1, we=1 asserted -> during reset we_n=1, oe_n=1, dat_oe=0, ack=0; after release, write completes with exactly one ack pulse.
- CPU write adr 0x20000 data 0xA5, no VGA -> we_n low exactly one cycle with adr=0x20000, dat=0xA5, dat_oe=1; ack 1 cycle later; CPU read 0x20000 returns O_wb_dat=0xA5 with ack.
- VGA req adr 0x40041 with SRAM model holding 0x3C -> oe_n low the next cycle, O_vga_dat=0x3C at the second edge after req; we_n stays 1.
- VGA req every 2nd cycle plus CPU read stb -> CPU read completes in a free slot, VGA data never corrupted, ack within 3 cycles of stb.
- stb and vga_req raised on the same edge -> VGA slot first, CPU slot the next cycle, single ack.
- With SRAM_ARB_WR_SETUP_EN: write interrupted by a VGA req after WSETUP -> WSETUP repeats, we_n low once, memory holds the written byte, single ack.
